// File: rtl/pc_sequencer.sv
// Run-control / PC-steering sequencer with a hardware return-address stack.
// Latency: strobes are combinational from state + decoded op; state/stack update 1 edge later.
// Backpressure: none; one decoded instruction is accepted per cycle while running.
//
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   go_i                  start/restart request (level)
//   rp_i                  current PC from program_counter
//   op_*_i, flag_zero_i   decoded instruction class and branch condition
//   pc_start_o            hold PC at start_address (IDLE/DONE/FAULT)
//   pc_branch_o, pc_jump2sub_o, pc_retFsub_o, pc_lj0_o..pc_lj3_o
//                         one-hot PC update strobes (at most one per cycle)
//   rl_o                  return link, top of the return-address stack
//   running_o, done_o, fault_o   state decode
//   err_ovf_o, err_unf_o  sticky stack overflow / underflow
//   sp_o                  stack occupancy 0..DEPTH
//   run_cycles_o          saturating count of cycles spent running
module pc_sequencer #(
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     go_i,
  input  logic [9:0]               rp_i,
  input  logic                     op_bz_i,
  input  logic                     op_bnz_i,
  input  logic                     flag_zero_i,
  input  logic                     op_call_i,
  input  logic                     op_ret_i,
  input  logic                     op_halt_i,
  input  logic                     op_lj_i,
  input  logic [1:0]               op_lj_sel_i,
  output logic                     pc_start_o,
  output logic                     pc_branch_o,
  output logic                     pc_jump2sub_o,
  output logic                     pc_retFsub_o,
  output logic                     pc_lj0_o,
  output logic                     pc_lj1_o,
  output logic                     pc_lj2_o,
  output logic                     pc_lj3_o,
  output logic [9:0]               rl_o,
  output logic                     running_o,
  output logic                     done_o,
  output logic                     fault_o,
  output logic                     err_ovf_o,
  output logic                     err_unf_o,
  output logic [$clog2(DEPTH):0]   sp_o,
  output logic [CW-1:0]            run_cycles_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   SP_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW:0]     sp_q, sp_d;
  logic            err_ovf_q, err_ovf_d;
  logic            err_unf_q, err_unf_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [9:0]      stack_q [DEPTH];

  logic            push;
  logic            br_taken;
  logic            stk_full;
  logic            stk_empty;
  logic [3:0]      lj_vec;
  logic [AW-1:0]   top_idx;

  assign br_taken  = (op_bz_i & flag_zero_i) | (op_bnz_i & ~flag_zero_i);
  assign stk_full  = (sp_q == SP_FULL);
  assign stk_empty = (sp_q == '0);

  // Low bits minus one wrap correctly even when sp == DEPTH (low bits 0 -> DEPTH-1).
  assign top_idx   = sp_q[AW-1:0] - 1'b1;

  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    err_ovf_d     = err_ovf_q;
    err_unf_d     = err_unf_q;
    cyc_d         = cyc_q;
    push          = 1'b0;
    pc_start_o    = 1'b0;
    pc_branch_o   = 1'b0;
    pc_jump2sub_o = 1'b0;
    pc_retFsub_o  = 1'b0;
    lj_vec        = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        pc_start_o = 1'b1;
        if (go_i) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (cyc_q != CNT_MAX) cyc_d = cyc_q + 1'b1;
        // Strict priority chain: halt > taken branch > call > return > long jump.
        // A not-taken branch falls through to the lower-priority checks.
        if (op_halt_i) begin
          state_d = ST_DONE;
        end else if (br_taken) begin
          pc_branch_o = 1'b1;
        end else if (op_call_i) begin
          if (stk_full) begin
            err_ovf_d = 1'b1;
            state_d   = ST_FAULT;
          end else begin
            pc_jump2sub_o = 1'b1;
            push          = 1'b1;
            sp_d          = sp_q + 1'b1;
          end
        end else if (op_ret_i) begin
          if (stk_empty) begin
            err_unf_d = 1'b1;
            state_d   = ST_FAULT;
          end else begin
            pc_retFsub_o = 1'b1;
            sp_d         = sp_q - 1'b1;
          end
        end else if (op_lj_i) begin
          lj_vec[op_lj_sel_i] = 1'b1;
        end
      end

      ST_DONE, ST_FAULT: begin
        pc_start_o = 1'b1;
        // Restart wipes stack occupancy, sticky errors and the cycle count together.
        if (go_i) begin
          state_d   = ST_RUN;
          sp_d      = '0;
          err_ovf_d = 1'b0;
          err_unf_d = 1'b0;
          cyc_d     = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      sp_q      <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
      cyc_q     <= '0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
      cyc_q     <= cyc_d;
    end
  end

  // Stack storage is never cleared; only sp is. The write is still gated by
  // reset so a call coinciding with reset leaves no trace.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && push) begin
      stack_q[sp_q[AW-1:0]] <= rp_i + 10'd1;
    end
  end

  assign rl_o         = stk_empty ? 10'h000 : stack_q[top_idx];
  assign pc_lj0_o     = lj_vec[0];
  assign pc_lj1_o     = lj_vec[1];
  assign pc_lj2_o     = lj_vec[2];
  assign pc_lj3_o     = lj_vec[3];
  assign running_o    = (state_q == ST_RUN);
  assign done_o       = (state_q == ST_DONE);
  assign fault_o      = (state_q == ST_FAULT);
  assign err_ovf_o    = err_ovf_q;
  assign err_unf_o    = err_unf_q;
  assign sp_o         = sp_q;
  assign run_cycles_o = cyc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic, all checked against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DONE  = 2;
  localparam int M_FAULT = 3;

  logic clk;
  logic rst_n;
  logic go;
  logic [9:0] rp;
  logic op_bz, op_bnz, flag_zero, op_call, op_ret, op_halt, op_lj;
  logic [1:0] op_lj_sel;

  logic pc_start, pc_branch, pc_jump2sub, pc_retFsub;
  logic pc_lj0, pc_lj1, pc_lj2, pc_lj3;
  logic [9:0] rl;
  logic running, done, fault, err_ovf, err_unf;
  logic [$clog2(DEPTH):0] sp;
  logic [CW-1:0] run_cycles;

  int checks = 0;
  int errors = 0;

  // reference model
  int         m_state;
  logic [9:0] m_stack[$];
  logic       m_ovf, m_unf;
  int         m_cyc;

  pc_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .go_i(go), .rp_i(rp),
    .op_bz_i(op_bz), .op_bnz_i(op_bnz), .flag_zero_i(flag_zero),
    .op_call_i(op_call), .op_ret_i(op_ret), .op_halt_i(op_halt),
    .op_lj_i(op_lj), .op_lj_sel_i(op_lj_sel),
    .pc_start_o(pc_start), .pc_branch_o(pc_branch),
    .pc_jump2sub_o(pc_jump2sub), .pc_retFsub_o(pc_retFsub),
    .pc_lj0_o(pc_lj0), .pc_lj1_o(pc_lj1), .pc_lj2_o(pc_lj2), .pc_lj3_o(pc_lj3),
    .rl_o(rl), .running_o(running), .done_o(done), .fault_o(fault),
    .err_ovf_o(err_ovf), .err_unf_o(err_unf), .sp_o(sp), .run_cycles_o(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (time %0t, required < 1000000)", $time);
    $fatal(1);
  end

  // {pc_start, branch, jump2sub, retFsub, lj3, lj2, lj1, lj0}
  function automatic logic [7:0] act_strobes();
    return {pc_start, pc_branch, pc_jump2sub, pc_retFsub, pc_lj3, pc_lj2, pc_lj1, pc_lj0};
  endfunction

  function automatic logic [7:0] exp_strobes();
    logic [7:0] v;
    v = 8'h00;
    if (m_state != M_RUN) begin
      v[7] = 1'b1;
    end else if (!op_halt) begin
      if ((op_bz && flag_zero) || (op_bnz && !flag_zero)) v[6] = 1'b1;
      else if (op_call) begin
        if (m_stack.size() < DEPTH) v[5] = 1'b1;
      end else if (op_ret) begin
        if (m_stack.size() > 0) v[4] = 1'b1;
      end else if (op_lj) begin
        v[op_lj_sel] = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [9:0] exp_rl();
    if (m_stack.size() == 0) return 10'h000;
    return m_stack[$];
  endfunction

  function automatic logic [4:0] exp_status();
    return {m_state == M_RUN, m_state == M_DONE, m_state == M_FAULT, m_ovf, m_unf};
  endfunction

  function automatic void model_step();
    logic [9:0] ret_addr;
    if (!rst_n) begin
      m_state = M_IDLE;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_cyc = 0;
      return;
    end
    case (m_state)
      M_IDLE: if (go) m_state = M_RUN;
      M_RUN: begin
        if (m_cyc < CMAX) m_cyc = m_cyc + 1;
        if (op_halt) m_state = M_DONE;
        else if ((op_bz && flag_zero) || (op_bnz && !flag_zero)) begin
        end else if (op_call) begin
          if (m_stack.size() == DEPTH) begin
            m_ovf = 1'b1;
            m_state = M_FAULT;
          end else begin
            ret_addr = rp + 10'd1;
            m_stack.push_back(ret_addr);
          end
        end else if (op_ret) begin
          if (m_stack.size() == 0) begin
            m_unf = 1'b1;
            m_state = M_FAULT;
          end else begin
            void'(m_stack.pop_back());
          end
        end
      end
      default: begin
        if (go) begin
          m_state = M_RUN;
          m_stack.delete();
          m_ovf = 1'b0;
          m_unf = 1'b0;
          m_cyc = 0;
        end
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_ops();
    op_bz = 0; op_bnz = 0; flag_zero = 0; op_call = 0;
    op_ret = 0; op_halt = 0; op_lj = 0; op_lj_sel = 2'd0;
  endtask

  task automatic start_run();
    clear_ops();
    go = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    go = 1;
    tick();
    go = 0;
  endtask

  task automatic test_reset();
    clear_ops();
    go = 0; rp = 10'h000; rst_n = 0;
    tick(); tick();
    rst_n = 1;
    settle();
    checks++;
    if (act_strobes() !== 8'h80) begin
      errors++; $display("FAIL reset_strobes: got %b want %b", act_strobes(), 8'h80);
    end
    checks++;
    if ({running, done, fault, err_ovf, err_unf} !== 5'b0) begin
      errors++; $display("FAIL reset_status: got %b want 00000", {running, done, fault, err_ovf, err_unf});
    end
    checks++;
    if (rl !== 10'h000 || sp !== '0 || run_cycles !== '0) begin
      errors++; $display("FAIL reset_regs: rl=%h sp=%0d cyc=%0d want 0/0/0", rl, sp, run_cycles);
    end
  endtask

  task automatic test_go();
    go = 1;
    settle();
    checks++;
    if (pc_start !== 1'b1 || running !== 1'b0) begin
      errors++; $display("FAIL go_before_edge: pc_start=%b running=%b want 1/0", pc_start, running);
    end
    tick();
    go = 0;
    settle();
    checks++;
    if (pc_start !== 1'b0 || running !== 1'b1 || run_cycles !== '0) begin
      errors++; $display("FAIL go_after_edge: pc_start=%b running=%b cyc=%0d want 0/1/0", pc_start, running, run_cycles);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      settle();
      checks++;
      if (run_cycles !== CW'(i)) begin
        errors++; $display("FAIL run_count: got %0d want %0d", run_cycles, i);
      end
    end
  endtask

  task automatic test_branch_priority();
    start_run();
    rp = 10'h123;
    op_bz = 1; flag_zero = 1; op_call = 1; op_lj = 1; op_lj_sel = 2'd2;
    settle();
    checks++;
    if (act_strobes() !== 8'b0100_0000) begin
      errors++; $display("FAIL branch_prio: got %b want %b", act_strobes(), 8'b0100_0000);
    end
    tick();
    settle();
    checks++;
    if (sp !== '0) begin
      errors++; $display("FAIL branch_sp: got %0d want 0", sp);
    end
    flag_zero = 0;
    settle();
    checks++;
    if (act_strobes() !== 8'b0010_0000) begin
      errors++; $display("FAIL branch_fallthru: got %b want %b", act_strobes(), 8'b0010_0000);
    end
    tick();
    clear_ops();
    settle();
    checks++;
    if (sp !== 4'd1 || rl !== 10'h124) begin
      errors++; $display("FAIL fallthru_push: sp=%0d rl=%h want 1/124", sp, rl);
    end
  endtask

  task automatic test_call_ret();
    start_run();
    op_call = 1; rp = 10'h3FF;
    settle();
    checks++;
    if (act_strobes() !== 8'b0010_0000) begin
      errors++; $display("FAIL call_strobe: got %b want %b", act_strobes(), 8'b0010_0000);
    end
    tick();
    settle();
    checks++;
    if (rl !== 10'h000 || sp !== 4'd1) begin
      errors++; $display("FAIL call_wrap: rl=%h sp=%0d want 000/1", rl, sp);
    end
    rp = 10'h045;
    tick();
    clear_ops();
    settle();
    checks++;
    if (rl !== 10'h046 || sp !== 4'd2) begin
      errors++; $display("FAIL call_second: rl=%h sp=%0d want 046/2", rl, sp);
    end
    op_ret = 1;
    settle();
    checks++;
    if (act_strobes() !== 8'b0001_0000) begin
      errors++; $display("FAIL ret_strobe: got %b want %b", act_strobes(), 8'b0001_0000);
    end
    tick();
    clear_ops();
    settle();
    checks++;
    if (rl !== 10'h000 || sp !== 4'd1) begin
      errors++; $display("FAIL ret_pop: rl=%h sp=%0d want 000/1", rl, sp);
    end
  endtask

  task automatic test_overflow();
    start_run();
    op_call = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rp = 10'(16 * i + 3);
      tick();
    end
    settle();
    checks++;
    if (sp !== 4'd8 || rl !== 10'h074) begin
      errors++; $display("FAIL ovf_fill: sp=%0d rl=%h want 8/074", sp, rl);
    end
    checks++;
    if (act_strobes() !== 8'h00) begin
      errors++; $display("FAIL ovf_strobe: got %b want 00000000", act_strobes());
    end
    tick();
    clear_ops();
    settle();
    checks++;
    if ({err_ovf, fault, pc_start, running} !== 4'b1110 || sp !== 4'd8) begin
      errors++; $display("FAIL ovf_fault: ovf/fault/start/run=%b sp=%0d want 1110/8", {err_ovf, fault, pc_start, running}, sp);
    end
    go = 1;
    tick();
    go = 0;
    settle();
    checks++;
    if (running !== 1'b1 || sp !== '0 || err_ovf !== 1'b0 || rl !== 10'h000) begin
      errors++; $display("FAIL ovf_restart: run=%b sp=%0d ovf=%b rl=%h want 1/0/0/000", running, sp, err_ovf, rl);
    end
  endtask

  task automatic test_underflow();
    start_run();
    op_ret = 1;
    settle();
    checks++;
    if (act_strobes() !== 8'h00) begin
      errors++; $display("FAIL unf_strobe: got %b want 00000000", act_strobes());
    end
    tick();
    clear_ops();
    settle();
    checks++;
    if ({err_unf, err_ovf, fault, pc_start} !== 4'b1011) begin
      errors++; $display("FAIL unf_fault: unf/ovf/fault/start=%b want 1011", {err_unf, err_ovf, fault, pc_start});
    end
  endtask

  task automatic test_halt_restart();
    start_run();
    tick(); tick();
    op_halt = 1; op_call = 1; op_lj = 1;
    settle();
    checks++;
    if (act_strobes() !== 8'h00) begin
      errors++; $display("FAIL halt_strobe: got %b want 00000000", act_strobes());
    end
    tick();
    clear_ops();
    settle();
    checks++;
    if ({done, pc_start, running} !== 3'b110 || sp !== '0 || run_cycles !== 4'd3) begin
      errors++; $display("FAIL halt_done: done/start/run=%b sp=%0d cyc=%0d want 110/0/3", {done, pc_start, running}, sp, run_cycles);
    end
    go = 1;
    tick();
    settle();
    checks++;
    if (running !== 1'b1 || run_cycles !== '0) begin
      errors++; $display("FAIL halt_restart: run=%b cyc=%0d want 1/0", running, run_cycles);
    end
    tick(); tick();
    go = 0;
    settle();
    checks++;
    if (running !== 1'b1 || run_cycles !== 4'd2) begin
      errors++; $display("FAIL go_held: run=%b cyc=%0d want 1/2", running, run_cycles);
    end
  endtask

  task automatic test_saturation();
    start_run();
    for (int i = 0; i < 20; i++) tick();
    settle();
    checks++;
    if (run_cycles !== 4'(CMAX)) begin
      errors++; $display("FAIL saturate: got %0d want %0d", run_cycles, CMAX);
    end
  endtask

  task automatic test_mid_reset();
    start_run();
    op_call = 1; rp = 10'h100;
    tick();
    rp = 10'h200; rst_n = 0;
    tick();
    rst_n = 1;
    clear_ops();
    settle();
    checks++;
    if ({running, pc_start} !== 2'b01 || sp !== '0 || rl !== 10'h000) begin
      errors++; $display("FAIL mid_reset: run/start=%b sp=%0d rl=%h want 01/0/000", {running, pc_start}, sp, rl);
    end
  endtask

  task automatic test_random();
    start_run();
    for (int n = 0; n < 500; n++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      go        = ($urandom_range(0, 7) == 0);
      rp        = 10'($urandom);
      op_bz     = ($urandom_range(0, 5) == 0);
      op_bnz    = ($urandom_range(0, 5) == 0);
      flag_zero = 1'($urandom);
      op_call   = ($urandom_range(0, 2) == 0);
      op_ret    = ($urandom_range(0, 3) == 0);
      op_halt   = ($urandom_range(0, 15) == 0);
      op_lj     = ($urandom_range(0, 2) == 0);
      op_lj_sel = 2'($urandom);
      settle();
      checks++;
      if (act_strobes() !== exp_strobes()) begin
        errors++; $display("FAIL rnd_strobes[%0d]: got %b want %b", n, act_strobes(), exp_strobes());
      end
      checks++;
      if ({running, done, fault, err_ovf, err_unf} !== exp_status()) begin
        errors++; $display("FAIL rnd_status[%0d]: got %b want %b", n, {running, done, fault, err_ovf, err_unf}, exp_status());
      end
      checks++;
      if (rl !== exp_rl() || sp !== 4'(m_stack.size())) begin
        errors++; $display("FAIL rnd_stack[%0d]: rl=%h sp=%0d want %h/%0d", n, rl, sp, exp_rl(), m_stack.size());
      end
      checks++;
      if (run_cycles !== CW'(m_cyc)) begin
        errors++; $display("FAIL rnd_cycles[%0d]: got %0d want %0d", n, run_cycles, m_cyc);
      end
      tick();
    end
    rst_n = 1;
    clear_ops();
    go = 0;
  endtask

  initial begin
    m_state = M_IDLE;
    m_ovf = 0; m_unf = 0; m_cyc = 0;
    rst_n = 0; go = 0; rp = '0;
    clear_ops();
    test_reset();
    test_go();
    test_branch_priority();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_halt_restart();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
